// File: rtl/cyq_scan_ctrl.sv
// Scan controller for a 4-digit 74HC138/74HC4511 multiplexed display: lamp test, blanked digit
// slots and tear-free frame loads. Define SLC_LZB_EN to enable leading-zero blanking.
module cyq_scan_ctrl #(
  parameter int unsigned DIV       = 8,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        MR,
  input  logic        en,
  input  logic        ld,
  input  logic [15:0] D,
  output logic        ack,
  output logic [1:3]  E,
  output logic [2:0]  A,
  output logic [3:0]  BCD,
  output logic        BI_n,
  output logic        LT_n,
  output logic [1:0]  digit
);

  typedef enum logic [1:0] {LAMP = 2'd0, IDLE = 2'd1, BLANK = 2'd2, SHOW = 2'd3} state_t;

  localparam logic [15:0] SLOT_LAST  = 16'(DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);
  localparam logic [2:0]  E_ON       = 3'b001;
  localparam logic [2:0]  E_OFF      = 3'b100;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  digit_q, digit_d;
  logic [15:0] shadow_q, shadow_d;
  logic        ack_q, ack_d;
  logic [2:0]  e_q, e_d;
  logic [2:0]  a_q, a_d;
  logic [3:0]  bcd_q, bcd_d;
  logic        bi_n_q, bi_n_d;
  logic        lt_n_q, lt_n_d;

  function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] k);
    logic [3:0] n;
    case (k)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      2'd3:    n = v[15:12];
      default: n = 4'd0;
    endcase
    return n;
  endfunction

`ifdef SLC_LZB_EN
  // True when digit k and every more significant digit are zero; digit 0 always stays lit.
  function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] k);
    logic z;
    case (k)
      2'd3:    z = (v[15:12] == 4'd0);
      2'd2:    z = (v[15:8] == 8'd0);
      2'd1:    z = (v[15:4] == 12'd0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction
`endif

  // Next-state logic; frames only reload on the 3->0 wrap so a frame is never torn.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    shadow_d = shadow_q;
    ack_d    = 1'b0;
    case (state_q)
      LAMP: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = 16'd0;
          digit_d = digit_q + 2'd1;
          if (digit_q == 2'd3) begin
            state_d = en ? BLANK : IDLE;
          end else begin
            state_d = LAMP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      IDLE: begin
        cnt_d   = 16'd0;
        digit_d = 2'd0;
        if (ld && !ack_q) begin
          ack_d    = 1'b1;
          shadow_d = D;
        end else begin
          ack_d = 1'b0;
        end
        state_d = en ? BLANK : IDLE;
      end
      BLANK: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = (cnt_q == BLANK_LAST) ? SHOW : BLANK;
      end
      SHOW: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d = 16'd0;
          if (digit_q == 2'd3 && ld && !ack_q) begin
            ack_d    = 1'b1;
            shadow_d = D;
          end else begin
            ack_d = 1'b0;
          end
          if (en) begin
            state_d = BLANK;
            digit_d = digit_q + 2'd1;
          end else begin
            state_d = IDLE;
            digit_d = 2'd0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = LAMP;
    endcase
  end

  // Output decode from next state so the pins are registered alongside the state.
  always_comb begin
    e_d    = E_OFF;
    a_d    = {1'b0, digit_d};
    bcd_d  = nibble_sel(shadow_d, digit_d);
    bi_n_d = 1'b0;
    lt_n_d = 1'b1;
    case (state_d)
      LAMP: begin
        e_d    = E_ON;
        bcd_d  = 4'd0;
        lt_n_d = 1'b0;
      end
      IDLE: a_d = 3'd0;
      BLANK: e_d = E_OFF;
      SHOW: begin
        e_d = E_ON;
`ifdef SLC_LZB_EN
        bi_n_d = !leading_zero(shadow_d, digit_d);
`else
        bi_n_d = 1'b1;
`endif
      end
      default: e_d = E_OFF;
    endcase
  end

  // State, counters, shadow frame and output registers.
  always_ff @(posedge clk or negedge MR) begin
    if (!MR) begin
      state_q  <= LAMP;
      cnt_q    <= 16'd0;
      digit_q  <= 2'd0;
      shadow_q <= 16'h0000;
      ack_q    <= 1'b0;
      e_q      <= E_ON;
      a_q      <= 3'd0;
      bcd_q    <= 4'd0;
      bi_n_q   <= 1'b0;
      lt_n_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
      e_q      <= e_d;
      a_q      <= a_d;
      bcd_q    <= bcd_d;
      bi_n_q   <= bi_n_d;
      lt_n_q   <= lt_n_d;
    end
  end

  assign ack   = ack_q;
  assign E     = e_q;
  assign A     = a_q;
  assign BCD   = bcd_q;
  assign BI_n  = bi_n_q;
  assign LT_n  = lt_n_q;
  assign digit = digit_q;

endmodule

// File: tb/tb_cyq_scan_ctrl.sv
// Scoreboard bench for cyq_scan_ctrl: a frame/slot-arithmetic model predicts every cycle's outputs.
module tb_cyq_scan_ctrl;
  localparam int DIV       = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * DIV;
  localparam int M_LAMP    = 0;
  localparam int M_IDLE    = 1;
  localparam int M_SCAN    = 2;

  logic        clk = 1'b0;
  logic        MR  = 1'b1;
  logic        en  = 1'b0;
  logic        ld  = 1'b0;
  logic [15:0] D   = 16'h0000;
  logic        ack;
  logic [1:3]  E;
  logic [2:0]  A;
  logic [3:0]  BCD;
  logic        BI_n;
  logic        LT_n;
  logic [1:0]  digit;

  cyq_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .MR(MR), .en(en), .ld(ld), .D(D), .ack(ack), .E(E), .A(A),
    .BCD(BCD), .BI_n(BI_n), .LT_n(LT_n), .digit(digit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] e;
    logic [2:0] a;
    logic [3:0] bcd;
    logic       bi;
    logic       lt;
    logic       ack;
    logic [1:0] dig;
    logic       chk_bcd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode, cycles elapsed in that mode, frame contents, ack flag.
  int          m_mode;
  int          m_t;
  logic [15:0] m_shadow;
  logic        m_ack;
  logic        m_rst;

  logic        r_en;
  logic        r_req;
  logic [15:0] r_d;

  function automatic exp_t mk_exp();
    exp_t        r;
    int          dig;
    int          p;
    logic        lit;
    logic [15:0] upper;
    r     = '0;
    r.lt  = 1'b1;
    r.ack = m_ack;
    if (m_mode == M_LAMP) begin
      dig       = m_t / DIV;
      r.e       = 3'b001;
      r.dig     = 2'(dig);
      r.a       = 3'(dig);
      r.lt      = 1'b0;
      r.chk_bcd = m_rst;
    end else if (m_mode == M_IDLE) begin
      r.e = 3'b100;
    end else begin
      dig       = (m_t / DIV) % 4;
      p         = m_t % DIV;
      lit       = (p >= BLANK_CYC);
      upper     = m_shadow >> (4 * dig);
      r.e       = lit ? 3'b001 : 3'b100;
      r.a       = 3'(dig);
      r.dig     = 2'(dig);
      r.bcd     = upper[3:0];
      r.chk_bcd = 1'b1;
      r.bi      = lit;
`ifdef SLC_LZB_EN
      if (dig > 0 && upper == 16'h0000) r.bi = 1'b0;
`endif
    end
    return r;
  endfunction

  task automatic model_edge(input logic en_v, input logic ld_v, input logic [15:0] d_v);
    logic ack_prev;
    ack_prev = m_ack;
    m_ack    = 1'b0;
    m_rst    = 1'b0;
    if (m_mode == M_LAMP) begin
      if (m_t == FRAME - 1) begin
        m_t    = 0;
        m_mode = en_v ? M_SCAN : M_IDLE;
      end else begin
        m_t = m_t + 1;
      end
    end else if (m_mode == M_IDLE) begin
      if (ld_v && !ack_prev) begin
        m_ack    = 1'b1;
        m_shadow = d_v;
      end
      if (en_v) begin
        m_mode = M_SCAN;
        m_t    = 0;
      end
    end else begin
      if (m_t % DIV == DIV - 1) begin
        if (m_t / DIV == 3 && ld_v) begin
          m_ack    = 1'b1;
          m_shadow = d_v;
        end
        if (!en_v) begin
          m_mode = M_IDLE;
          m_t    = 0;
        end else begin
          m_t = (m_t + 1) % FRAME;
        end
      end else begin
        m_t = m_t + 1;
      end
    end
  endtask

  task automatic step(input logic en_v, input logic ld_v, input logic [15:0] d_v);
    en = en_v;
    ld = ld_v;
    D  = d_v;
    @(posedge clk);
    #1;
    model_edge(en_v, ld_v, d_v);
    exp_q.push_back(mk_exp());
  endtask

  // Called 1 time unit after a rising edge; asserts MR mid-cycle and replaces that cycle's prediction.
  task automatic do_reset();
    #2;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    MR       = 1'b0;
    m_mode   = M_LAMP;
    m_t      = 0;
    m_shadow = 16'h0000;
    m_ack    = 1'b0;
    m_rst    = 1'b1;
    #1;
    checks = checks + 1;
    if (E !== 3'b001 || A !== 3'd0 || BCD !== 4'd0 || BI_n !== 1'b0 || LT_n !== 1'b0 ||
        ack !== 1'b0 || digit !== 2'd0) begin
      errors = errors + 1;
      $display("FAIL reset state @%0t got E=%b A=%0d BCD=%h BI_n=%b LT_n=%b ack=%b digit=%0d",
               $time, E, A, BCD, BI_n, LT_n, ack, digit);
    end
    exp_q.push_back(mk_exp());
    @(posedge clk);
    #1;
    exp_q.push_back(mk_exp());
    MR = 1'b1;
  endtask

  task automatic goto_pos(input int dig, input int p);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_mode == M_SCAN && m_t == dig * DIV + p) begin
        hit = 1'b1;
        break;
      end
      step(1'b1, 1'b0, 16'h0000);
    end
    if (!hit && m_mode == M_SCAN && m_t == dig * DIV + p) hit = 1'b1;
    checks = checks + 1;
    if (!hit) begin
      errors = errors + 1;
      $display("FAIL goto_pos wait expired @%0t target digit=%0d pos=%0d", $time, dig, p);
    end
  endtask

  task automatic load_req(input logic [15:0] d_v, input logic en_v);
    logic got;
    got = 1'b0;
    for (int i = 0; i < FRAME + 4; i++) begin
      step(en_v, 1'b1, d_v);
      if (m_ack) begin
        got = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!got) begin
      errors = errors + 1;
      $display("FAIL load_req wait expired @%0t no ack for D=%h", $time, d_v);
    end
    step(en_v, 1'b0, d_v);
  endtask

  // Monitor: one prediction per falling edge, BCD compared only where it is defined.
  always @(negedge clk) begin
    exp_t w;
    if (exp_q.size() != 0) begin
      w      = exp_q.pop_front();
      checks = checks + 1;
      if (E !== w.e || A !== w.a || BI_n !== w.bi || LT_n !== w.lt || ack !== w.ack ||
          digit !== w.dig || (w.chk_bcd && BCD !== w.bcd)) begin
        errors = errors + 1;
        $display("FAIL outputs @%0t got E=%b A=%0d BCD=%h BI_n=%b LT_n=%b ack=%b digit=%0d want E=%b A=%0d BCD=%h(chk=%b) BI_n=%b LT_n=%b ack=%b digit=%0d",
                 $time, E, A, BCD, BI_n, LT_n, ack, digit, w.e, w.a, w.bcd, w.chk_bcd,
                 w.bi, w.lt, w.ack, w.dig);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    repeat (64) step(1'b1, 1'b0, 16'h0000);
    repeat (10) step(1'b0, 1'b0, 16'h0000);
    load_req(16'h1234, 1'b0);
    repeat (2) step(1'b0, 1'b0, 16'h0000);
    repeat (70) step(1'b1, 1'b0, 16'h0000);
    goto_pos(1, 3);
    load_req(16'h5678, 1'b1);
    repeat (40) step(1'b1, 1'b0, 16'h0000);
    goto_pos(2, 4);
    repeat (10) step(1'b0, 1'b0, 16'h0000);
    goto_pos(0, 3);
    repeat (10) step(1'b1, 1'b1, 16'hDEAD);
    repeat (40) step(1'b1, 1'b0, 16'h0000);
    goto_pos(3, 7);
    step(1'b0, 1'b1, 16'h9ABC);
    repeat (5) step(1'b0, 1'b0, 16'h0000);
    repeat (40) step(1'b1, 1'b0, 16'h0000);
    goto_pos(2, 5);
    do_reset();
    repeat (70) step(1'b1, 1'b0, 16'h0000);
    repeat (10) step(1'b0, 1'b0, 16'h0000);
    load_req(16'h0007, 1'b0);
    repeat (40) step(1'b1, 1'b0, 16'h0000);
    r_en  = 1'b1;
    r_req = 1'b0;
    r_d   = 16'h0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 4) r_en = !r_en;
      if (!r_req && $urandom_range(0, 15) == 0) begin
        r_req = 1'b1;
        r_d   = 16'($urandom);
      end else if (r_req && $urandom_range(0, 49) == 0) begin
        r_req = 1'b0;
      end
      step(r_en, r_req, r_d);
      if (m_ack) r_req = 1'b0;
    end
    step(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
